mux_scan_sequencer: RTL
=======================

# mux_scan_sequencer

Sequencer that sits directly upstream of the 4:1 select mux: it drives the mux select lines `S1`/`S0`, steps through a programmable subset of the four inputs, waits a settle time on each, samples the mux output `Y`, and packs the sampled bits into a 4-bit frame handed downstream over a valid/ready handshake. It turns the purely combinational mux into a time-multiplexed channel scanner for the SDR control/status path.

## Interface
- `SETTLE`, default 2: cycles held after each select change before sampling (≥1).
- `DWELL_W`, default 8: width of the per-channel dwell count.
- `clk` in 1: single clock domain, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `abort` in 1: synchronous sweep cancel.
- `ch_mask` in 4: channels to scan, bit n = input In; latched on accepted `start`.
- `dwell` in DWELL_W: extra hold cycles after each sample; latched on accepted `start`.
- `Y` in 1: output of the downstream-selected mux.
- `S1`, `S0` out 1: registered mux selects; {S1,S0} = channel index.
- `busy` out 1: high from accepted `start` until return to IDLE.
- `frame` out 4: sampled bits, bit n = channel n; unmasked bits 0.
- `frame_valid` out 1: frame available.
- `frame_ready` in 1: downstream accepts frame.

## Operation
- States: IDLE, SETTLE, SAMPLE, DWELL, DONE.
- IDLE: `start`=1 and `ch_mask`≠0 → latch mask/dwell, clear frame, load lowest set channel onto {S1,S0}, go SETTLE. `start` with `ch_mask`=0 ignored.
- SETTLE: SETTLE cycles, then SAMPLE.
- SAMPLE: 1 cycle; `Y` captured into `frame[ch]` at its closing edge. Then DWELL if dwell≠0, else advance.
- DWELL: `dwell` cycles, then advance.
- Advance: next set bit above current channel in latched mask → load onto {S1,S0}, go SETTLE; none left → DONE.
- DONE: `frame_valid`=1, `frame` stable until `frame_valid && frame_ready`; then IDLE.
- `abort`=1 in any non-IDLE state → IDLE at next edge, `frame_valid` never asserted, frame cleared; overrides everything else that cycle.
- `start` while busy ignored; `ch_mask`/`dwell` changes mid-sweep have no effect.
- Counter: one DWELL_W-bit down-counter shared by SETTLE and DWELL; no wrap, reload on each state entry.

## Timing
- Reset values: `S1`=`S0`=0, `busy`=0, `frame`=0, `frame_valid`=0, state IDLE.
- {S1,S0} changes on the edge that accepts `start` / advances; `busy` rises on that same edge.
- Per enabled channel: SETTLE + 1 + dwell cycles (SAMPLE is 1 cycle without macro).
- `frame_valid` rises k·(SETTLE+1+dwell) cycles after the `start` edge, k = popcount(mask).
- `frame_ready` pre-asserted: handshake completes first DONE cycle; `busy`, `frame_valid` drop next edge; new `start` accepted the cycle after.
- Select held constant throughout SETTLE/SAMPLE/DWELL; in IDLE the last channel is held.
- Reset mid-sweep: all outputs return to reset values immediately (async).

## Configuration
- `MUX_SCAN_MAJORITY_EN` defined: SAMPLE lasts 3 cycles; `Y` sampled each cycle, `frame[ch]` = majority of the three; per-channel time becomes SETTLE+3+dwell.
- Undefined: single-cycle sample as above.

## Structure
- Shared package `mux_scan_pkg`: state enum, `NUM_CH`=4, `SEL_W`=2, reset constants.
- One sub-module: `mux_scan_next_ch`, combinational priority finder returning next set mask bit above current index plus a `none` flag.

## Test plan
- Reset mid-sweep (mask 1111, during channel 2 SETTLE) → S=00, busy=0, frame_valid=0 immediately; no frame later.
- mask 1111, dwell 0, SETTLE 2, Y = I-index parity (I1,I3 high), ready=1 → S sequence 00,01,10,11 each 3 cycles; frame_valid at cycle 12; frame=4'b1010.
- mask 0101, dwell 3 → only S=00 and S=10 visited, 6 cycles each; frame_valid at cycle 12; frame bits 1,3 = 0.
- frame_ready held low 5 cycles in DONE → frame and frame_valid stable; second `start` ignored; accepted after handshake.
- `abort` during DWELL of channel 1 → IDLE next edge, busy=0, frame=0, no frame_valid.
- With `MUX_SCAN_MAJORITY_EN`, Y glitches low 1 of 3 sample cycles on high channel → frame bit 1; per-channel time SETTLE+3+dwell.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types, sizes and helpers for the 4:1 mux scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0]  c_sel_rst   = '0;
  localparam logic [NUM_CH-1:0] c_frame_rst = '0;

  // Lowest enabled channel; the sweep always starts from the bottom of the mask.
  function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first_ch = SEL_W'(i);
    end
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_sequencer_if.sv
// ============================================================================
// Module      : mux_scan_sequencer_if
// Description : Control, mux select/sense and frame handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
);

  logic               start;
  logic               abort;
  logic [NUM_CH-1:0]  ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic               Y;
  logic               S1;
  logic               S0;
  logic               busy;
  logic [NUM_CH-1:0]  frame;
  logic               frame_valid;
  logic               frame_ready;

  modport master (
    output start, abort, ch_mask, dwell, Y, frame_ready,
    input  S1, S0, busy, frame, frame_valid
  );

  modport slave (
    input  start, abort, ch_mask, dwell, Y, frame_ready,
    output S1, S0, busy, frame, frame_valid
  );

endinterface

`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
// ============================================================================
// Module      : mux_scan_next_ch
// Description : Finds the next enabled channel strictly above the current one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur,
  output logic [SEL_W-1:0]  o_nxt,
  output logic              o_none
);

  // Walk downward so the lowest qualifying channel is the one left standing.
  always_comb begin
    o_nxt  = i_cur;
    o_none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (SEL_W'(i) > i_cur)) begin
        o_nxt  = SEL_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// Module      : mux_scan_sequencer
// Description : Steps the 4:1 mux select over a channel mask, samples Y after
//               a settle time and hands out a 4-bit frame via valid/ready.
//               Build option MUX_SCAN_MAJORITY_EN: 3-cycle majority sampling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_sequencer_if.slave bus
);

  localparam logic [DWELL_W-1:0] c_settle_ld = DWELL_W'(SETTLE - 1);
`ifdef MUX_SCAN_MAJORITY_EN
  localparam logic [DWELL_W-1:0] c_sample_ld = DWELL_W'(2);
`else
  localparam logic [DWELL_W-1:0] c_sample_ld = '0;
`endif

  state_t              r_state;
  logic [DWELL_W-1:0]  r_cnt;
  logic [NUM_CH-1:0]   r_mask;
  logic [DWELL_W-1:0]  r_dwell;
  logic [SEL_W-1:0]    r_sel;
  logic                r_busy;
  logic [NUM_CH-1:0]   r_frame;
  logic                r_frame_valid;
`ifdef MUX_SCAN_MAJORITY_EN
  logic [1:0]          r_smp;
`endif

  logic [SEL_W-1:0]    w_nxt;
  logic                w_none;
  logic                w_sample_last;
  logic                w_advance;

  mux_scan_next_ch u_next_ch (
    .i_mask (r_mask),
    .i_cur  (r_sel),
    .o_nxt  (w_nxt),
    .o_none (w_none)
  );

  always_comb begin
`ifdef MUX_SCAN_MAJORITY_EN
    w_sample_last = (r_cnt == '0);
`else
    w_sample_last = 1'b1;
`endif
    w_advance = ((r_state == ST_SAMPLE) && w_sample_last && (r_dwell == '0)) ||
                ((r_state == ST_DWELL) && (r_cnt == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_mask        <= '0;
      r_dwell       <= '0;
      r_sel         <= c_sel_rst;
      r_busy        <= 1'b0;
      r_frame       <= c_frame_rst;
      r_frame_valid <= 1'b0;
`ifdef MUX_SCAN_MAJORITY_EN
      r_smp         <= '0;
`endif
    end else if (bus.abort && (r_state != ST_IDLE)) begin
      // Select is left where it is; only the sweep bookkeeping is dropped.
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame       <= c_frame_rst;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.ch_mask != '0)) begin
            r_mask  <= bus.ch_mask;
            r_dwell <= bus.dwell;
            r_frame <= c_frame_rst;
            r_sel   <= first_ch(bus.ch_mask);
            r_cnt   <= c_settle_ld;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_SAMPLE;
            r_cnt   <= c_sample_ld;
          end else begin
            r_cnt <= r_cnt - DWELL_W'(1);
          end
        end
        ST_SAMPLE: begin
`ifdef MUX_SCAN_MAJORITY_EN
          if (!w_sample_last) begin
            r_smp <= {r_smp[0], bus.Y};
            r_cnt <= r_cnt - DWELL_W'(1);
          end else begin
            r_frame[r_sel] <= maj3(r_smp[1], r_smp[0], bus.Y);
          end
`else
          r_frame[r_sel] <= bus.Y;
`endif
          if (w_sample_last && (r_dwell != '0)) begin
            r_state <= ST_DWELL;
            r_cnt   <= r_dwell - DWELL_W'(1);
          end
        end
        ST_DWELL: begin
          if (r_cnt != '0) r_cnt <= r_cnt - DWELL_W'(1);
        end
        ST_DONE: begin
          if (r_frame_valid && bus.frame_ready) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Leaving SAMPLE (no dwell) or DWELL: next channel, or finish the frame.
      if (w_advance) begin
        r_cnt <= c_settle_ld;
        if (w_none) begin
          r_state       <= ST_DONE;
          r_frame_valid <= 1'b1;
        end else begin
          r_state <= ST_SETTLE;
          r_sel   <= w_nxt;
        end
      end
    end
  end

  assign bus.S1          = r_sel[1];
  assign bus.S0          = r_sel[0];
  assign bus.busy        = r_busy;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_frame_valid;

endmodule

`default_nettype wire
